key_scan_debounce: RTL and testbench

Parametrised multi-channel push-button conditioner for the board front panel. Each of NUM_KEYS raw button inputs is synchronised, debounced independently, and turned into a clean level plus single-cycle press, release and long-press events. Keys are fully independent, so simultaneous presses are reported together rather than priority-masked. The block sits between the board pins and the user-interface control logic.

---
 rtl/key_scan_debounce.sv | 187 ++++++++++++++++++
 tb/tb_key_scan_debounce.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_scan_debounce.sv
// Multi-key push-button conditioner: sync, debounce, press/release/long events.
// Optional auto-repeat on long hold is built when KEY_REPEAT_EN is defined.
module key_scan_debounce #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] key_repeat,
    output logic                any_pressed
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HLAST = HW'(LONG_CYCLES - 1);
    localparam logic REL = ACTIVE_LOW;

`ifdef KEY_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] RLAST = RW'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DOWN = 2'd1,
        LONG = 2'd2
    } st_t;

    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;
    logic [NUM_KEYS-1:0] s;
    logic [NUM_KEYS-1:0] lvl;
    logic                any_q;

    // synchroniser idles at the released pin level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= {NUM_KEYS{REL}};
            sync2 <= {NUM_KEYS{REL}};
            any_q <= 1'b0;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
            any_q <= |lvl;
        end
    end

    assign s           = sync2 ^ {NUM_KEYS{REL}};
    assign any_pressed = any_q;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        logic [DW-1:0] dcnt;
        logic          lv;
        st_t           st;
        st_t           st_nx;
        logic [HW-1:0] hcnt;
        logic [HW-1:0] hcnt_nx;
        logic          press_nx;
        logic          rel_nx;
        logic          long_nx;
        logic          ks_q;
        logic          press_q;
        logic          rel_q;
        logic          long_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dcnt <= '0;
                lv   <= 1'b0;
            end else if (s[k] == lv) begin
                dcnt <= '0;
            end else if (dcnt == DLAST) begin
                dcnt <= '0;
                lv   <= ~lv;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end

        assign lvl[k] = lv;

        // release is tested first so it wins over the long point
        always_comb begin
            st_nx    = st;
            hcnt_nx  = hcnt;
            press_nx = 1'b0;
            rel_nx   = 1'b0;
            long_nx  = 1'b0;
            unique case (st)
                IDLE: begin
                    if (lv) begin
                        st_nx    = DOWN;
                        press_nx = 1'b1;
                        hcnt_nx  = '0;
                    end
                end
                DOWN: begin
                    if (!lv) begin
                        st_nx   = IDLE;
                        rel_nx  = 1'b1;
                        hcnt_nx = '0;
                    end else if (hcnt == HLAST) begin
                        st_nx   = LONG;
                        long_nx = 1'b1;
                    end else begin
                        hcnt_nx = hcnt + 1'b1;
                    end
                end
                LONG: begin
                    if (!lv) begin
                        st_nx   = IDLE;
                        rel_nx  = 1'b1;
                        hcnt_nx = '0;
                    end
                end
                default: begin
                    st_nx   = IDLE;
                    hcnt_nx = '0;
                end
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st      <= IDLE;
                hcnt    <= '0;
                ks_q    <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                long_q  <= 1'b0;
            end else begin
                st      <= st_nx;
                hcnt    <= hcnt_nx;
                ks_q    <= lv;
                press_q <= press_nx;
                rel_q   <= rel_nx;
                long_q  <= long_nx;
            end
        end

        assign key_state[k]   = ks_q;
        assign key_press[k]   = press_q;
        assign key_release[k] = rel_q;
        assign key_long[k]    = long_q;

`ifdef KEY_REPEAT_EN
        logic [RW-1:0] rcnt;
        logic          rep_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rcnt  <= '0;
                rep_q <= 1'b0;
            end else begin
                rep_q <= 1'b0;
                if (st == LONG && lv) begin
                    if (rcnt == RLAST) begin
                        rcnt  <= '0;
                        rep_q <= 1'b1;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end else begin
                    rcnt <= '0;
                end
            end
        end

        assign key_repeat[k] = rep_q;
`endif
    end

`ifndef KEY_REPEAT_EN
    // repeat period only matters when the repeat counter is built
    assign key_repeat = {NUM_KEYS{(REPEAT_CYCLES < 0)}};
`endif

endmodule

// File: tb/tb_key_scan_debounce.sv
// Bench for key_scan_debounce: directed table, hand sequences, random vs model.
// Repeat expectations follow KEY_REPEAT_EN when it is defined for the build.
module tb_key_scan_debounce;

    localparam int NK = 4;
    localparam int D  = 8;
    localparam int L  = 40;
    localparam int R  = 10;
`ifdef KEY_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] key_in = 4'hF;
    logic [NK-1:0] key_state;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] key_long;
    logic [NK-1:0] key_repeat;
    logic          any_pressed;

    key_scan_debounce #(
        .NUM_KEYS(NK),
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES(L),
        .REPEAT_CYCLES(R),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_in(key_in),
        .key_state(key_state),
        .key_press(key_press),
        .key_release(key_release),
        .key_long(key_long),
        .key_repeat(key_repeat),
        .any_pressed(any_pressed)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int m = 0;
    int lastrst = 0;
    logic [NK-1:0] rawh [0:8191];
    logic [NK-1:0] sh [0:8191];
    logic [NK-1:0] lvl = '0;
    logic [NK-1:0] st_prev = '0;
    int pe [NK];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @edge %0d: got %0h expected %0h",
                     nm, m, act, exp);
        end
    endtask

    // One clock: drive at negedge, model the edge, compare 1 time unit later.
    // Model: the debounced level flips once the last D synchronised
    // samples all disagree with it; key_state shows it one edge later.
    task automatic cyc(input logic [NK-1:0] kin, input logic r);
        logic [NK-1:0] st, pr, rl, lg, rp, nl;
        bit all_d;
        st = '0; pr = '0; rl = '0; lg = '0; rp = '0;
        @(negedge clk);
        key_in = kin;
        rst = r;
        @(posedge clk);
        m++;
        rawh[m] = kin;
        if (r) begin
            lastrst = m;
            sh[m] = '0;
            lvl = '0;
            for (int k = 0; k < NK; k++) pe[k] = -1;
        end else begin
            for (int k = 0; k < NK; k++)
                sh[m][k] = (m - 2 > lastrst) ? ~rawh[m-2][k] : 1'b0;
            st = lvl;
            pr = lvl & ~st_prev;
            rl = ~lvl & st_prev;
            nl = lvl;
            for (int k = 0; k < NK; k++) begin
                all_d = 1'b1;
                for (int j = 0; j < D; j++)
                    if (m - j <= lastrst || sh[m-j][k] == lvl[k])
                        all_d = 1'b0;
                if (all_d) nl[k] = ~lvl[k];
            end
            lvl = nl;
            for (int k = 0; k < NK; k++) begin
                if (pr[k]) pe[k] = m;
                else if (!st[k]) pe[k] = -1;
                lg[k] = (pe[k] >= 0) && (m - pe[k] == L);
                rp[k] = REP && (pe[k] >= 0) && (m - pe[k] > L) &&
                        ((m - pe[k] - L) % R == 0);
            end
        end
        st_prev = st;
        #1;
        chk("key_state", key_state, st);
        chk("key_press", key_press, pr);
        chk("key_release", key_release, rl);
        chk("key_long", key_long, lg);
        chk("key_repeat", key_repeat, rp);
        chk("any_pressed", any_pressed, |st);
    endtask

    typedef struct {
        logic [NK-1:0] kin;
        logic          r;
        int            n;
        logic [NK-1:0] st;
        logic [NK-1:0] pr;
        logic [NK-1:0] rl;
        logic          any;
    } vec_t;

    function automatic vec_t mk(logic [NK-1:0] kin, logic r, int n,
                                logic [NK-1:0] st, logic [NK-1:0] pr,
                                logic [NK-1:0] rl, logic any);
        vec_t v;
        v.kin = kin; v.r = r; v.n = n;
        v.st = st; v.pr = pr; v.rl = rl; v.any = any;
        return v;
    endfunction

    vec_t tbl [$];

    initial begin
        int tp, tl, tr, r1, r2, nrep, n;
        bit found;
        logic [NK-1:0] kin;
        for (int k = 0; k < NK; k++) pe[k] = -1;

        // reset, clean press/release of key0
        tbl.push_back(mk(4'hF, 1'b1, 3, 4'h0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(4'hF, 1'b0, 5, 4'h0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(4'hE, 1'b0, 9, 4'h0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(4'hE, 1'b0, 1, 4'h0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(4'hE, 1'b0, 1, 4'h1, 4'h1, 4'h0, 1'b1));
        tbl.push_back(mk(4'hE, 1'b0, 1, 4'h1, 4'h0, 4'h0, 1'b1));
        tbl.push_back(mk(4'hF, 1'b0, 10, 4'h1, 4'h0, 4'h0, 1'b1));
        tbl.push_back(mk(4'hF, 1'b0, 1, 4'h0, 4'h0, 4'h1, 1'b0));
        tbl.push_back(mk(4'hF, 1'b0, 1, 4'h0, 4'h0, 4'h0, 1'b0));
        // bounce on key1: lows of 3..7 cycles
        tbl.push_back(mk(4'hD, 1'b0, 3, 4'h0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(4'hF, 1'b0, 4, 4'h0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(4'hD, 1'b0, 7, 4'h0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(4'hF, 1'b0, 3, 4'h0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(4'hD, 1'b0, 5, 4'h0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(4'hF, 1'b0, 6, 4'h0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(4'hD, 1'b0, 4, 4'h0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(4'hF, 1'b0, 12, 4'h0, 4'h0, 4'h0, 1'b0));
        // key0 and key3 together
        tbl.push_back(mk(4'h6, 1'b0, 10, 4'h0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(4'h6, 1'b0, 1, 4'h9, 4'h9, 4'h0, 1'b1));
        tbl.push_back(mk(4'h6, 1'b0, 1, 4'h9, 4'h0, 4'h0, 1'b1));
        tbl.push_back(mk(4'hF, 1'b0, 10, 4'h9, 4'h0, 4'h0, 1'b1));
        tbl.push_back(mk(4'hF, 1'b0, 1, 4'h0, 4'h0, 4'h9, 1'b0));
        tbl.push_back(mk(4'hF, 1'b0, 2, 4'h0, 4'h0, 4'h0, 1'b0));

        foreach (tbl[i]) begin
            for (int c = 0; c < tbl[i].n; c++) cyc(tbl[i].kin, tbl[i].r);
            chk("tbl_state", key_state, tbl[i].st);
            chk("tbl_press", key_press, tbl[i].pr);
            chk("tbl_release", key_release, tbl[i].rl);
            chk("tbl_any", any_pressed, tbl[i].any);
        end

        // hold key2: long at +40, repeats at +10/+20 when built
        found = 1'b0; tp = 0;
        for (int c = 0; c < 30 && !found; c++) begin
            cyc(4'hB, 1'b0);
            if (key_press[2]) begin found = 1'b1; tp = m; end
        end
        chk("k2_press_seen", found, 1'b1);
        found = 1'b0; tl = 0;
        for (int c = 0; c < 60 && !found; c++) begin
            cyc(4'hB, 1'b0);
            if (key_long[2]) begin found = 1'b1; tl = m; end
        end
        chk("k2_long_seen", found, 1'b1);
        chk("k2_long_delay", tl - tp, L);
        r1 = -1; r2 = -1; nrep = 0;
        for (int c = 0; c < 25; c++) begin
            cyc(4'hB, 1'b0);
            if (key_repeat != '0) begin
                nrep++;
                if (r1 < 0) r1 = m;
                else if (r2 < 0) r2 = m;
            end
        end
        if (REP) begin
            chk("k2_rep1_delay", r1 - tl, R);
            chk("k2_rep2_delay", r2 - tl, 2 * R);
        end else begin
            chk("k2_no_repeat", nrep, 0);
        end
        for (int c = 0; c < 14; c++) cyc(4'hF, 1'b0);

        // reset while key1 is in LONG
        found = 1'b0;
        for (int c = 0; c < 80 && !found; c++) begin
            cyc(4'hD, 1'b0);
            if (key_long[1]) found = 1'b1;
        end
        chk("k1_long_pre_rst", found, 1'b1);
        for (int c = 0; c < 3; c++) cyc(4'hD, 1'b0);
        for (int c = 0; c < 3; c++) begin
            cyc(4'hD, 1'b1);
            chk("rst_outputs",
                {key_state, key_press, key_release, key_long, key_repeat,
                 any_pressed}, '0);
        end
        tr = m;
        found = 1'b0; tp = 0;
        for (int c = 0; c < 30 && !found; c++) begin
            cyc(4'hD, 1'b0);
            if (key_press[1]) begin found = 1'b1; tp = m; end
        end
        chk("k1_repress_seen", found, 1'b1);
        chk("k1_repress_delay", tp - (tr + 1), 2 + D);
        found = 1'b0; tl = 0;
        for (int c = 0; c < 60 && !found; c++) begin
            cyc(4'hD, 1'b0);
            if (key_long[1]) begin found = 1'b1; tl = m; end
        end
        chk("k1_long_seen", found, 1'b1);
        chk("k1_long_delay", tl - tp, L);
        for (int c = 0; c < 14; c++) cyc(4'hF, 1'b0);

        // random segments checked cycle by cycle against the model
        while (m < 5000) begin
            if ($urandom_range(0, 39) == 0) begin
                n = $urandom_range(1, 3);
                for (int c = 0; c < n; c++) cyc(key_in, 1'b1);
            end else begin
                kin = 4'($urandom);
                if ($urandom_range(0, 2) == 0) n = $urandom_range(1, 7);
                else n = $urandom_range(8, 75);
                for (int c = 0; c < n; c++) cyc(kin, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
